multicycle_control: RTL and testbench

- FSM control unit for the multi-cycle MIPS processor. It sequences each instruction through IF/ID/EX/MEM/WB-style states and drives per-state datapath strobes.
- Memory accesses use a ready handshake. The block also keeps a retired-instruction counter and a memory-wait watchdog.
- It sits between the IR opcode/funct fields and the shared datapath: PC, IR, ALU, register file and unified memory.

---
 rtl/multicycle_control.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM control unit for the multi-cycle MIPS datapath.
// It steps each instruction through IF/ID/EX/MEM/WB-style states and decodes
// the per-state datapath strobes combinationally. It also counts retired
// instructions and runs a watchdog on memory-wait states.
// Optional build macro: MULTICYCLE_CONTROL_EXCEPTION_EN. When it is defined,
// an illegal instruction traps to an EXC state that drives exc_take/EPCWrite.
// Without it, an illegal instruction retires as a NOP.
module multicycle_control #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 15,
    parameter int MEM_WAIT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             LuOp,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
    output logic             exc_take,
    output logic             EPCWrite,
`endif
    output logic             mem_timeout
);

    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EX     = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_MEM_WR = 4'd4;
    localparam logic [3:0] S_WB     = 4'd5;
    localparam logic [3:0] S_BR     = 4'd6;
    localparam logic [3:0] S_JMP    = 4'd7;
    localparam logic [3:0] S_EXC    = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // The wait counter only needs to reach WAIT_LIMIT, where it saturates.
    localparam int              WAIT_W   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    logic [3:0]        stateReg;
    logic [3:0]        stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitNext;
    logic              ready;
    logic              waitInc;
    logic              isRType;
    logic              isShiftImm;
    logic              isJr;
    logic              isJalr;
    logic              rAluLegal;
    logic              goesEx;
    logic              goesBr;
    logic              goesJmp;

    // With MEM_WAIT=0 the memory is treated as always completing in one cycle.
    assign ready   = mem_ready || (MEM_WAIT == 0);
    assign state   = stateReg;
    assign waitInc = ((stateReg == S_IF) || (stateReg == S_MEM_RD) || (stateReg == S_MEM_WR))
                     && !mem_ready;

    // Classify the instruction in IR into its execution path.
    always_comb begin
        isRType    = (OpCode == OP_RTYPE);
        isShiftImm = isRType && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
        isJr       = isRType && (Funct == FN_JR);
        isJalr     = isRType && (Funct == FN_JALR);
        case (Funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b: rAluLegal = 1'b1;
            default:      rAluLegal = 1'b0;
        endcase
        goesEx  = (isRType && rAluLegal)
                  || (OpCode == OP_LW)   || (OpCode == OP_SW)    || (OpCode == OP_LUI)
                  || (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_ANDI)
                  || (OpCode == OP_SLTI) || (OpCode == OP_SLTIU);
        goesBr  = (OpCode == OP_BEQ) || (OpCode == OP_BNE);
        goesJmp = (OpCode == OP_J) || (OpCode == OP_JAL) || isJr || isJalr;
    end

    // Next-state selection; unused encodings fall back to fetch.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IF:     if (ready) stateNext = S_ID;
            S_ID: begin
                if (goesEx)       stateNext = S_EX;
                else if (goesBr)  stateNext = S_BR;
                else if (goesJmp) stateNext = S_JMP;
                else begin
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
                    stateNext = S_EXC;
`else
                    stateNext = S_IF;
`endif
                end
            end
            S_EX: begin
                if (OpCode == OP_LW)      stateNext = S_MEM_RD;
                else if (OpCode == OP_SW) stateNext = S_MEM_WR;
                else                      stateNext = S_WB;
            end
            S_MEM_RD: if (ready) stateNext = S_WB;
            S_MEM_WR: if (ready) stateNext = S_IF;
            default:  stateNext = S_IF;
        endcase
    end

    // Per-state strobe decode; everything is held low while reset is asserted.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 4'b0000;
        PCSource   = 2'b00;
        ExtOp      = 1'b0;
        LuOp       = 1'b0;
        instr_done = 1'b0;
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
        exc_take   = 1'b0;
        EPCWrite   = 1'b0;
`endif
        if (!reset) begin
            case (stateReg)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = ready;
                    PCWrite = ready;
                end
                S_ID: begin
                    // Branch target is computed early into ALUOut.
                    ALUSrcB = 2'b11;
`ifndef MULTICYCLE_CONTROL_EXCEPTION_EN
                    // Illegal instructions retire here as a NOP.
                    instr_done = !(goesEx || goesBr || goesJmp);
`endif
                end
                S_EX: begin
                    ALUSrcA = isShiftImm ? 2'b10 : 2'b01;
                    ALUSrcB = isRType ? 2'b00 : 2'b10;
                    if (isRType)
                        ALUOp = {OpCode[0], 3'b010};
                    else if (OpCode == OP_ANDI)
                        ALUOp = {OpCode[0], 3'b100};
                    else if ((OpCode == OP_SLTI) || (OpCode == OP_SLTIU))
                        ALUOp = {OpCode[0], 3'b101};
                    else
                        ALUOp = {OpCode[0], 3'b000};
                    ExtOp = (OpCode != OP_ANDI);
                    LuOp  = (OpCode == OP_LUI);
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = ready;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = isRType ? 2'b01 : 2'b00;
                    MemtoReg   = (OpCode == OP_LW) ? 2'b01 : 2'b00;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    ALUSrcA    = 2'b01;
                    ALUOp      = {OpCode[0], 3'b001};
                    PCSource   = 2'b01;
                    PCWrite    = Zero ^ OpCode[0];
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = (isJr || isJalr) ? 2'b11 : 2'b10;
                    if (OpCode == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end else if (isJalr) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
                S_EXC: begin
                    EPCWrite = 1'b1;
                    exc_take = 1'b1;
                    PCWrite  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Wait counter: restarts on every state change, saturates at the limit.
    always_comb begin
        waitNext = waitCnt;
        if (stateNext != stateReg)
            waitNext = '0;
        else if (waitInc && (waitCnt != WAIT_MAX))
            waitNext = waitCnt + WAIT_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) stateReg <= S_IF;
        else       stateReg <= stateNext;
    end

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (reset)           instr_count <= '0;
        else if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end

    // Watchdog: sticky flag once a single wait reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            waitCnt <= waitNext;
            if ((WAIT_LIMIT > 0) && (waitNext == WAIT_MAX))
                mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed, table-driven bench for multicycle_control.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_ILL  = 6'h3f;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;

`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
    localparam int ILL = 0;
`else
    localparam int ILL = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]  ALUOp;
    logic        ExtOp, LuOp;
    logic [3:0]  state;
    logic        instr_done;
    logic [31:0] instr_count;
    logic        mem_timeout;
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
    logic        exc_take, EPCWrite;
`endif

    multicycle_control dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp), .state(state),
        .instr_done(instr_done), .instr_count(instr_count),
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
        .exc_take(exc_take), .EPCWrite(EPCWrite),
`endif
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [22:0] word;
        int          cnt;
        logic [1:0]  exc;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Pack the strobes as {PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,
    // RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,ExtOp,LuOp,instr_done}.
    function automatic logic [22:0] cw(input logic pcw, irw, iord, mrd, mwr, rgw,
                                       input logic [1:0] rdst, m2r, srcA, srcB,
                                       input logic [3:0] aluop, input logic [1:0] pcsrc,
                                       input logic ext, lu, done);
        return {pcw, irw, iord, mrd, mwr, rgw, rdst, m2r, srcA, srcB, aluop, pcsrc, ext, lu, done};
    endfunction

    function automatic logic [22:0] actualWord();
        return {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp, instr_done};
    endfunction

    task automatic addv(input logic rst, input logic [5:0] op, fn, input logic zero, rdy,
                        input logic [3:0] st, input logic [22:0] word, input int cnt,
                        input logic [1:0] exc);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.zero = zero; v.rdy = rdy;
        v.st = st; v.word = word; v.cnt = cnt; v.exc = exc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [22:0] wIf, wIfStall, wId, wExR, wExI, wWbR, wWbI, wMemRd;

    initial begin
        wIf      = cw(1,1,0,1,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000, 2'b00, 0,0,0);
        wIfStall = cw(0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000, 2'b00, 0,0,0);
        wId      = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 4'b0000, 2'b00, 0,0,0);
        wExR     = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 4'b0010, 2'b00, 1,0,0);
        wExI     = cw(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 4'b1000, 2'b00, 1,0,0);
        wWbR     = cw(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 0,0,1);
        wWbI     = cw(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 0,0,1);
        wMemRd   = cw(0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 0,0,0);

        // reset: state IF, all strobes gated off
        addv(1, OP_R, FN_ADD, 0, 1, 4'd0, '0, 0, 2'b00);
        // add
        addv(0, OP_R, FN_ADD, 0, 1, 4'd0, wIf, 0, 2'b00);
        addv(0, OP_R, FN_ADD, 0, 1, 4'd1, wId, 0, 2'b00);
        addv(0, OP_R, FN_ADD, 0, 1, 4'd2, wExR, 0, 2'b00);
        addv(0, OP_R, FN_ADD, 0, 1, 4'd5, wWbR, 0, 2'b00);
        // lw with three stall cycles in MEM_RD
        addv(0, OP_LW, 6'h00, 0, 1, 4'd0, wIf, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 1, 4'd1, wId, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 1, 4'd2, wExI, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 0, 4'd3, wMemRd, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 0, 4'd3, wMemRd, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 0, 4'd3, wMemRd, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 1, 4'd3, wMemRd, 1, 2'b00);
        addv(0, OP_LW, 6'h00, 0, 1, 4'd5, cw(0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 4'b0000, 2'b00, 0,0,1), 1, 2'b00);
        // sw
        addv(0, OP_SW, 6'h00, 0, 1, 4'd0, wIf, 2, 2'b00);
        addv(0, OP_SW, 6'h00, 0, 1, 4'd1, wId, 2, 2'b00);
        addv(0, OP_SW, 6'h00, 0, 1, 4'd2, wExI, 2, 2'b00);
        addv(0, OP_SW, 6'h00, 0, 1, 4'd4, cw(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 0,0,1), 2, 2'b00);
        // beq taken
        addv(0, OP_BEQ, 6'h00, 1, 1, 4'd0, wIf, 3, 2'b00);
        addv(0, OP_BEQ, 6'h00, 1, 1, 4'd1, wId, 3, 2'b00);
        addv(0, OP_BEQ, 6'h00, 1, 1, 4'd6, cw(1,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 4'b0001, 2'b01, 0,0,1), 3, 2'b00);
        // bne with Zero=1: not taken
        addv(0, OP_BNE, 6'h00, 1, 1, 4'd0, wIf, 4, 2'b00);
        addv(0, OP_BNE, 6'h00, 1, 1, 4'd1, wId, 4, 2'b00);
        addv(0, OP_BNE, 6'h00, 1, 1, 4'd6, cw(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 4'b1001, 2'b01, 0,0,1), 4, 2'b00);
        // jal
        addv(0, OP_JAL, 6'h00, 0, 1, 4'd0, wIf, 5, 2'b00);
        addv(0, OP_JAL, 6'h00, 0, 1, 4'd1, wId, 5, 2'b00);
        addv(0, OP_JAL, 6'h00, 0, 1, 4'd7, cw(1,0,0,0,0,1, 2'b10,2'b10,2'b00,2'b00, 4'b0000, 2'b10, 0,0,1), 5, 2'b00);
        // jr
        addv(0, OP_R, FN_JR, 0, 1, 4'd0, wIf, 6, 2'b00);
        addv(0, OP_R, FN_JR, 0, 1, 4'd1, wId, 6, 2'b00);
        addv(0, OP_R, FN_JR, 0, 1, 4'd7, cw(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b11, 0,0,1), 6, 2'b00);
        // sll uses shamt as operand A
        addv(0, OP_R, FN_SLL, 0, 1, 4'd0, wIf, 7, 2'b00);
        addv(0, OP_R, FN_SLL, 0, 1, 4'd1, wId, 7, 2'b00);
        addv(0, OP_R, FN_SLL, 0, 1, 4'd2, cw(0,0,0,0,0,0, 2'b00,2'b00,2'b10,2'b00, 4'b0010, 2'b00, 1,0,0), 7, 2'b00);
        addv(0, OP_R, FN_SLL, 0, 1, 4'd5, wWbR, 7, 2'b00);
        // andi zero-extends
        addv(0, OP_ANDI, 6'h00, 0, 1, 4'd0, wIf, 8, 2'b00);
        addv(0, OP_ANDI, 6'h00, 0, 1, 4'd1, wId, 8, 2'b00);
        addv(0, OP_ANDI, 6'h00, 0, 1, 4'd2, cw(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 4'b0100, 2'b00, 0,0,0), 8, 2'b00);
        addv(0, OP_ANDI, 6'h00, 0, 1, 4'd5, wWbI, 8, 2'b00);
        // illegal opcode 3f
        addv(0, OP_ILL, 6'h00, 0, 1, 4'd0, wIf, 9, 2'b00);
        addv(0, OP_ILL, 6'h00, 0, 1, 4'd1, cw(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 4'b0000, 2'b00, 0,0,ILL[0]), 9, 2'b00);
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
        addv(0, OP_ILL, 6'h00, 0, 1, 4'd8, cw(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 0,0,0), 9, 2'b11);
`endif
        // fetch stall, then reset in the middle of an instruction
        addv(0, OP_R, FN_ADD, 0, 0, 4'd0, wIfStall, 9 + ILL, 2'b00);
        addv(0, OP_R, FN_ADD, 0, 1, 4'd0, wIf, 9 + ILL, 2'b00);
        addv(1, OP_R, FN_ADD, 0, 1, 4'd1, '0, 9 + ILL, 2'b00);
        addv(0, OP_R, FN_ADD, 0, 1, 4'd0, wIf, 0, 2'b00);

        reset = 1'b1; OpCode = OP_R; Funct = FN_ADD; Zero = 1'b0; mem_ready = 1'b1;
        tick();
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; OpCode = vecs[i].op; Funct = vecs[i].fn;
            Zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d.strobes", i), 32'(actualWord()), 32'(vecs[i].word));
            chk($sformatf("v%0d.count", i), instr_count, vecs[i].cnt);
`ifdef MULTICYCLE_CONTROL_EXCEPTION_EN
            chk($sformatf("v%0d.exc", i), 32'({exc_take, EPCWrite}), 32'(vecs[i].exc));
`endif
            $display("vec %0d op=%02h fn=%02h rdy=%0b state=%0d strobes=%06h count=%0d",
                     i, vecs[i].op, vecs[i].fn, vecs[i].rdy, state, actualWord(), instr_count);
            tick();
        end

        // Watchdog: 15 low cycles in IF set the sticky flag; reset clears it.
        reset = 1'b1; mem_ready = 1'b0; OpCode = OP_R; Funct = FN_ADD;
        tick();
        reset = 1'b0;
        repeat (14) tick();
        chk("wd.after14", 32'(mem_timeout), 32'd0);
        tick();
        chk("wd.after15", 32'(mem_timeout), 32'd1);
        chk("wd.stillIF", 32'(state), 32'd0);
        mem_ready = 1'b1;
        tick();
        chk("wd.resumeID", 32'(state), 32'd1);
        repeat (3) tick();
        chk("wd.sticky", 32'(mem_timeout), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wd.resetClr", 32'(mem_timeout), 32'd0);
        $display("watchdog sequence done timeout=%0b", mem_timeout);

        // Wait counter restarts between memory states: 10 + 10 low cycles stay below the limit.
        reset = 1'b1; mem_ready = 1'b0; OpCode = OP_LW; Funct = 6'h00;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("wc.inMemRd", 32'(state), 32'd3);
        repeat (10) tick();
        chk("wc.noTimeout", 32'(mem_timeout), 32'd0);
        chk("wc.holdMemRd", 32'(state), 32'd3);
        mem_ready = 1'b1;
        tick();
        chk("wc.wb", 32'(state), 32'd5);
        tick();
        chk("wc.count", instr_count, 32'd1);
        $display("wait-clear sequence done state=%0d count=%0d", state, instr_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
